// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin whole-frame arbiter for the Tx byte stream.
// Latches the modulation mode per frame, truncates long frames, inserts gaps.
module tx_frame_arbiter #(
  parameter int unsigned MAX_FRAME_LEN = 64,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic        clk_1M024,
  input  logic        rst_n_1M024,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  input  logic        s0_tlast,
  output logic        s0_tready,
  input  logic [3:0]  s0_mode,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  input  logic        s1_tlast,
  output logic        s1_tready,
  input  logic [3:0]  s1_mode,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  input  logic        m_tready,
  output logic [3:0]  MODE_CTRL,
  output logic        active_src,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic [7:0]  frames_trunc
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DROP,
    GAP
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(MAX_FRAME_LEN - 1);
  localparam logic [3:0] GAP_LAST =
    4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam state_t END_ST = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t      state_q;
  state_t      state_d;
  logic        sel_q;
  logic [3:0]  mode_q;
  logic [7:0]  cnt_q;
  logic [3:0]  gap_q;
  logic [15:0] sent_q;
  logic [7:0]  trunc_q;

  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_last;
  logic        at_max;
  logic        grant_sel;
  logic [3:0]  grant_raw;
  logic [3:0]  grant_mode;
  logic        grant;
  logic        cnt_inc;
  logic        fin_ok;
  logic        fin_trunc;

  assign src_data  = sel_q ? s1_tdata  : s0_tdata;
  assign src_valid = sel_q ? s1_tvalid : s0_tvalid;
  assign src_last  = sel_q ? s1_tlast  : s0_tlast;
  assign at_max    = (cnt_q == LAST_IDX);

  // On a tie the source that did not hold the last grant wins.
  assign grant_sel = (s0_tvalid & s1_tvalid) ? ~sel_q : s1_tvalid;
  assign grant_raw = grant_sel ? s1_mode : s0_mode;
  assign grant_mode = $onehot(grant_raw) ? grant_raw : 4'b0001;

  always_comb begin
    state_d   = state_q;
    m_tdata   = 8'd0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tuser   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    grant     = 1'b0;
    cnt_inc   = 1'b0;
    fin_ok    = 1'b0;
    fin_trunc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s0_tvalid | s1_tvalid) begin
          grant   = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        m_tdata   = src_data;
        m_tvalid  = src_valid;
        m_tlast   = src_last | at_max;
        m_tuser   = (cnt_q == 8'd0);
        s0_tready = ~sel_q & m_tready;
        s1_tready = sel_q & m_tready;
        if (src_valid & m_tready) begin
          cnt_inc = 1'b1;
          if (src_last) begin
            fin_ok  = 1'b1;
            state_d = END_ST;
          end else if (at_max) begin
            fin_trunc = 1'b1;
            state_d   = DROP;
          end
        end
      end
      DROP: begin
        s0_tready = ~sel_q;
        s1_tready = sel_q;
        if (src_valid & src_last) begin
          state_d = END_ST;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      state_q <= IDLE;
      sel_q   <= 1'b1;
      mode_q  <= 4'b0001;
      cnt_q   <= 8'd0;
      gap_q   <= 4'd0;
      sent_q  <= 16'd0;
      trunc_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        sel_q  <= grant_sel;
        mode_q <= grant_mode;
        cnt_q  <= 8'd0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (state_q == GAP) begin
        gap_q <= gap_q + 4'd1;
      end else begin
        gap_q <= 4'd0;
      end
      if (fin_ok | fin_trunc) begin
        sent_q <= sent_q + 16'd1;
      end
      if (fin_trunc && trunc_q != 8'hFF) begin
        trunc_q <= trunc_q + 8'd1;
      end
    end
  end

  assign MODE_CTRL    = mode_q;
  assign active_src   = sel_q;
  assign busy         = (state_q != IDLE);
  assign frames_sent  = sent_q;
  assign frames_trunc = trunc_q;

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Round-robin frame arbiter and mode scheduler in front of the Tx chain's byte-stream input (`data_tdata/tlast/tuser/tvalid`). It shares the single modulator between two framed byte sources. It grants whole frames only and drives `MODE_CTRL` per frame, so the modulation mode changes only on frame boundaries. It also truncates runaway frames and inserts an inter-frame gap.

## Interface
Parameters:
- `MAX_FRAME_LEN`, 64: maximum accepted beats per frame (2..255).
- `GAP_CYCLES`, 2: idle cycles between frames (0..15).

Ports:
- `clk_1M024`  in  1  byte/symbol-domain clock.
- `rst_n_1M024`  in  1  reset, asynchronous assert, active-low.
- `s0_tdata`  in  8  source 0 byte.
- `s0_tvalid`  in  1  source 0 valid.
- `s0_tlast`  in  1  source 0 last byte of frame.
- `s0_tready`  out  1  source 0 ready.
- `s0_mode`  in  4  source 0 requested mode; one-hot 0001 BPSK, 0010 QPSK, 0100 MIX.
- `s1_tdata`, `s1_tvalid`, `s1_tlast`, `s1_tready`, `s1_mode`: same set for source 1.
- `m_tdata`  out  8  to Tx `data_tdata`.
- `m_tvalid`  out  1  to Tx `data_tvalid`.
- `m_tlast`  out  1  to Tx `data_tlast`.
- `m_tuser`  out  1  to Tx `data_tuser`; 1 on the first beat of each frame.
- `m_tready`  in  1  Tx ready.
- `MODE_CTRL`  out  4  mode for the Tx/Rx datapath.
- `active_src`  out  1  index of the current or last grant.
- `busy`  out  1  state is not IDLE.
- `frames_sent`  out  16  completed frames, wraps.
- `frames_trunc`  out  8  truncated frames, saturates at 255.

## Operation
- States:
  - IDLE: all `s*_tready`=0, `m_tvalid`=0.
  - XFER: pass-through from the granted source. `m_tdata`=`sX_tdata`, `m_tvalid`=`sX_tvalid`, `sX_tready`=`m_tready`. The other source's `tready`=0.
  - DROP: granted `sX_tready`=1, `m_tvalid`=0.
  - GAP: all ready/valid 0.
- IDLE -> XFER when any `sX_tvalid`=1.
  - Only one valid: grant it.
  - Both valid: grant the source not equal to `active_src`.
  - On grant, register `active_src`, load `MODE_CTRL` from `sX_mode`, clear the beat counter.
  - A `sX_mode` that is not one-hot loads 0001 (BPSK).
- XFER:
  - Beat = `m_tvalid & m_tready`. The counter increments per beat.
  - `m_tuser`=1 while the counter is 0.
  - `m_tlast` = `sX_tlast` OR (counter == `MAX_FRAME_LEN`-1).
  - Beat with `sX_tlast`=1: go to GAP and increment `frames_sent`.
  - Beat at counter == `MAX_FRAME_LEN`-1 with `sX_tlast`=0: the forced `m_tlast` completes the frame. Increment `frames_sent` and `frames_trunc`, then go to DROP.
- DROP: discard source beats until a beat with `sX_tlast`=1, then go to GAP.
- GAP: count `GAP_CYCLES` cycles, then go to IDLE. With `GAP_CYCLES`=0, go to IDLE directly from XFER or DROP.
- `MODE_CTRL` holds from grant through GAP and IDLE until the next grant.
- A change on `sX_mode` mid-frame is ignored.

## Timing
- Reset values:
  - state IDLE, `MODE_CTRL`=0001, `active_src`=1 (so s0 wins the first tie).
  - counters 0, `busy`=0.
  - all `tready`/`m_tvalid`/`m_tlast`/`m_tuser`=0.
- Reset assertion mid-frame forces all of the above immediately, asynchronously. The downstream frame is left unterminated; the Tx chain is reset alongside.
- Grant latency: `sX_tvalid` seen in IDLE at edge N puts XFER and the new `MODE_CTRL` in effect after edge N. The first byte can transfer at edge N+1.
- Data path is combinational (zero latency) in XFER. State, counters and `MODE_CTRL` are registered.
- Frame-to-frame spacing: last beat at edge N, GAP for `GAP_CYCLES` cycles, IDLE, then next grant. The earliest next first beat is at edge N+`GAP_CYCLES`+2.
- `m_tready`=0 stalls the counter and holds the source; no beat is lost or duplicated.
- A single-beat frame (`tlast` on the first beat) has `m_tuser`=`m_tlast`=1 on the same beat.
- `MAX_FRAME_LEN` reached exactly with `tlast`=1: counts as normal, not truncated; no DROP.

## Test plan
- Solo frame:
  - Stimulus: s0 sends 4 bytes 0x11..0x14, mode 0010, `m_tready`=1.
  - Response: `MODE_CTRL`=0010 one cycle before the first beat. `m_tuser` is high on 0x11 only and `m_tlast` on 0x14. `frames_sent`=1. Next grant no earlier than 3 cycles later.
- Round robin:
  - Stimulus: both sources continuously valid with 2-byte frames, modes 0001/0100.
  - Response: grants alternate s0, s1, s0, s1. `MODE_CTRL` alternates 0001/0100 and changes only in IDLE→XFER.
- Truncation:
  - Stimulus: `MAX_FRAME_LEN`=4, s1 sends 7 bytes.
  - Response: 4 bytes out with `m_tlast` on the 4th. 3 bytes are dropped with `s1_tready`=1 and `m_tvalid`=0. `frames_trunc`=1, `frames_sent`=1.
- Backpressure:
  - Stimulus: toggle `m_tready` randomly during a 10-byte frame.
  - Response: the output byte sequence equals the input, and the counter matches the beat count.
- Invalid mode and mid-frame change:
  - Stimulus: `s0_mode`=0011 at grant, switched to 0010 mid-frame.
  - Response: `MODE_CTRL` stays 0001 for the whole frame.
- Reset mid-frame:
  - Stimulus: deassert `rst_n_1M024` during byte 3.
  - Response: all outputs return to reset values immediately. After release, s0 is granted first.
